// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: op codes, FSM states
// and the divide-op classifier.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MADD  = 3'd4,
      OP_MADDU = 3'd5,
      OP_MSUB  = 3'd6,
      OP_MSUBU = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_t;

   function automatic logic is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring radix-2 divider on operand magnitudes: one quotient bit per
// enabled cycle, last_o flags the final iteration.
module mdu_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             last_o,
   output logic [WIDTH-1:0] quo_o,
   output logic [WIDTH-1:0] rem_o
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, diff;
   logic [WIDTH:0]   shifted;
   logic [CW-1:0]    cnt_q;
   logic             ge;

   // quo_q doubles as the dividend shift register; its MSB feeds the remainder
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign ge      = shifted >= {1'b0, dsr_q};
   assign diff    = shifted[WIDTH-1:0] - dsr_q;

   always_comb begin
      rem_d = shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
      if (ge) begin
         rem_d = diff;
         quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         rem_q <= '0;
         quo_q <= dividend_i;
         dsr_q <= divisor_i;
         cnt_q <= '0;
      end else if (en_i) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign last_o = en_i && (cnt_q == CW'(WIDTH - 1));
   assign quo_o  = quo_q;
   assign rem_o  = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; shift-add multiply here,
// restoring divide in mdu_divider. MULT_ACCUM_EN enables MADD/MSUB ops 4-7.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int BPC = WIDTH / MUL_CYCLES;
   localparam int CW  = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [2:0]         op_q;
   logic               neg_q, neg_rem_q, bz_q;
   logic [WIDTH-1:0]   a_q, mcand_q, hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0] prod_q, prod_step, prod_fix;
   logic [CW-1:0]      mcnt_q;
   logic               done_q, done_d, dz_q, dz_d;
   logic               accept, op_signed, op_is_mul, div_last;
   logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, quo_fix, rem_fix;
   logic [WIDTH:0]     sum;

   assign op_signed = ~op[0];
   assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

`ifdef MULT_ACCUM_EN
   assign op_is_mul = !is_div(op);
`else
   assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            accept = 1'b1;
            if (is_div(op))     state_d = DIV;
            else if (op_is_mul) state_d = MUL;
         end
         MUL:     if (mcnt_q == CW'(MUL_CYCLES - 1)) state_d = FIX;
         DIV:     if (div_last) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Multiplier sits in prod_q's low half and shifts out as product bits shift in
   always_comb begin
      prod_step = prod_q;
      sum       = '0;
      for (int i = 0; i < BPC; i++) begin
         sum       = {1'b0, prod_step[2*WIDTH-1:WIDTH]} + (prod_step[0] ? {1'b0, mcand_q} : '0);
         prod_step = {sum, prod_step[WIDTH-1:1]};
      end
   end

   assign prod_fix = neg_q     ? -prod_q : prod_q;
   assign quo_fix  = neg_q     ? -quo    : quo;
   assign rem_fix  = neg_rem_q ? -rem    : rem;

   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      dz_d   = dz_q;
      done_d = 1'b0;
      if (state_q == IDLE) begin
         if (hi_we)  hi_d = wdata;
         if (lo_we)  lo_d = wdata;
         if (accept) dz_d = 1'b0;
      end else if (state_q == FIX) begin
         done_d = 1'b1;
         if (is_div(op_q)) begin
            if (bz_q) begin
               hi_d = a_q;
               lo_d = '1;
               dz_d = 1'b1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
         end else begin
`ifdef MULT_ACCUM_EN
            if (op_q[2])
               {hi_d, lo_d} = op_q[1] ? ({hi_q, lo_q} - prod_fix) : ({hi_q, lo_q} + prod_fix);
            else
               {hi_d, lo_d} = prod_fix;
`else
            {hi_d, lo_d} = prod_fix;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         op_q      <= '0;
         a_q       <= '0;
         bz_q      <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         mcand_q   <= '0;
         prod_q    <= '0;
         mcnt_q    <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         if (accept) begin
            op_q      <= op;
            a_q       <= a;
            bz_q      <= (b == '0);
            neg_q     <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= op_signed & a[WIDTH-1];
            mcand_q   <= a_mag;
            prod_q    <= {{WIDTH{1'b0}}, b_mag};
            mcnt_q    <= '0;
         end else if (state_q == MUL) begin
            prod_q <= prod_step;
            mcnt_q <= mcnt_q + 1'b1;
         end
      end
   end

   mdu_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst_n     (reset),
      .load_i    (accept && is_div(op)),
      .en_i      (state_q == DIV),
      .dividend_i(a_mag),
      .divisor_i (b_mag),
      .last_o    (div_last),
      .quo_o     (quo),
      .rem_o     (rem)
   );

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign div_by_zero = dz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + random bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0, b = '0, wdata = '0;
   logic        hi_we = 1'b0, lo_we = 1'b0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_err    = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   localparam int LAT = 33;

   mult_div_unit #(.WIDTH(32), .MUL_CYCLES(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // {hi,lo} from plain arithmetic; signed divide truncates toward zero in SV
   function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
      longint sa, sb;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      case (o)
         3'd0:    return 64'(sa * sb);
         3'd1:    return {32'b0, av} * {32'b0, bv};
         3'd2:    return (bv == 0) ? {av, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
         default: return (bv == 0) ? {av, 32'hFFFFFFFF} : {av % bv, av / bv};
      endcase
   endfunction

   task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input bit wr, input bit disturb);
      logic [63:0] r;
      int          nb;
      bit          held;
      r = ref_res(o, av, bv);
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv;
      if (wr) begin
         wdata = $urandom; hi_we = 1'b1; lo_we = 1'b1;
         m_hi = wdata; m_lo = wdata;
      end
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 3'($urandom); a = $urandom; b = $urandom;
      chk("dz_clear_on_start", 32'(div_by_zero), 32'd0);
      nb = 0; held = 1'b1;
      while (busy && !done && nb < 200) begin
         if (hi !== m_hi || lo !== m_lo) held = 1'b0;
         nb++;
         if (disturb && nb == 5) begin
            start = 1'b1; op = 3'd3; a = $urandom; b = $urandom;
            hi_we = 1'b1; wdata = 32'h1234;
         end else begin
            start = 1'b0; hi_we = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0; hi_we = 1'b0;
      chk("busy_cycles", 32'(nb), 32'(LAT));
      chk("hilo_held", 32'(held), 32'd1);
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("hi", hi, r[63:32]);
      chk("lo", lo, r[31:0]);
      chk("div_by_zero", 32'(div_by_zero), 32'((o[1] == 1'b1) && (bv == 0)));
      m_hi = r[63:32]; m_lo = r[31:0];
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      bit seen;
      logic [2:0] ro;
      logic [31:0] ra, rb;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dz", 32'(div_by_zero), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      reset = 1'b1;

      do_op(3'd1, 32'h00000200, 32'h00000030, 1'b0, 1'b0);
      do_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      do_op(3'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);
      do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
      do_op(3'd3, 32'h00003100, 32'h00000000, 1'b0, 1'b0);
      do_op(3'd3, 32'h00003100, 32'h00000004, 1'b0, 1'b0);
      do_op(3'd2, 32'h00000007, 32'h00000000, 1'b0, 1'b0);
      do_op(3'd1, 32'h0000BEEF, 32'h00012345, 1'b0, 1'b1);

      // idle MTHI / MTLO writes
      @(negedge clk); hi_we = 1'b1; wdata = 32'hCAFE0001;
      @(negedge clk); hi_we = 1'b0; m_hi = 32'hCAFE0001;
      chk("mthi", hi, m_hi);
      chk("mthi_lo_kept", lo, m_lo);
      lo_we = 1'b1; wdata = 32'h5A5A0002;
      @(negedge clk); lo_we = 1'b0; m_lo = 32'h5A5A0002;
      chk("mtlo", lo, m_lo);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F0003;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b0; m_hi = 32'h0F0F0003; m_lo = 32'h0F0F0003;
      chk("mthilo_hi", hi, m_hi);
      chk("mthilo_lo", lo, m_lo);

      do_op(3'd0, 32'hFFFF8000, 32'h00007FFF, 1'b1, 1'b0);

`ifndef MULT_ACCUM_EN
      @(negedge clk);
      start = 1'b1; op = 3'd4; a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         if (busy || done) seen = 1'b1;
         @(negedge clk);
      end
      chk("noop_quiet", 32'(seen), 32'd0);
      chk("noop_hi", hi, m_hi);
      chk("noop_lo", lo, m_lo);
`endif

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 15);
            2:       rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         do_op(ro, ra, rb, ($urandom_range(0, 3) == 0), 1'b0);
      end

      // asynchronous reset in the middle of a divide
      @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h77770000;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
      start = 1'b1; op = 3'd2; a = $urandom; b = $urandom | 32'd1;
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_hi", hi, 32'd0);
      chk("rst_mid_lo", lo, 32'd0);
      @(negedge clk); reset = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (busy || done) seen = 1'b1;
      end
      chk("rst_mid_no_done", 32'(seen), 32'd0);
      chk("rst_mid_hi_after", hi, 32'd0);
      chk("rst_mid_lo_after", lo, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit owning the HI/LO register pair for the MIPS CPU datapath.
- Executes MULT/MULTU/DIV/DIVU as a multi-cycle radix-2 operation, so the ALU no longer needs a single-cycle combinational multiplier or divider.
- Provides MTHI/MTLO writes and continuous HI/LO read-out for MFHI/MFLO.
- The control unit stalls on `busy`.

Parameters:
- WIDTH, 32, operand and HI/LO register width; must be at least 4 and even.
- MUL_CYCLES, WIDTH, multiply iteration count (bits retired per cycle = WIDTH/MUL_CYCLES); WIDTH or WIDTH/2 only.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only when busy=0
- op  in  3  operation code, see package
- a  in  WIDTH  rs operand; multiplicand or dividend
- b  in  WIDTH  rt operand; multiplier or divisor
- hi_we  in  1  MTHI strobe
- lo_we  in  1  MTLO strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO updated by an operation
- div_by_zero  out  1  last DIV/DIVU had b=0; sticky
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi, lo, busy, done, div_by_zero all 0. Reset mid-operation aborts the operation; HI/LO stay 0 after release.
- States and transitions:
  - IDLE -> MUL on start with a multiply op; IDLE -> DIV on start with a divide op.
  - MUL or DIV -> FIX when the iteration counter reaches its terminal value.
  - FIX -> IDLE.
- Latency:
  - start accepted at edge E0; busy=1 from E0 to E0+N+1, where N = MUL_CYCLES or WIDTH.
  - hi/lo take the new result and done=1 for exactly one cycle starting at edge E0+N+1; busy=0 in that same cycle.
  - WIDTH=32, N=32: a new op can be accepted on the edge where done is sampled high.
- Operands a, b and op are captured at E0; later changes to them are ignored.
- start while busy=1: ignored, no queuing.
- Signed ops:
  - Operand magnitudes are taken at capture; sign correction is applied in FIX.
  - MULT: the 2*WIDTH two's-complement product goes to {hi,lo}.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Most-negative / -1: lo = most-negative value, hi = 0; no trap.
- Unsigned ops: plain magnitudes are used.
- Divide by zero (b=0): lo = all ones, hi = a unchanged; div_by_zero=1. Same latency as a normal divide.
- div_by_zero clears on the next accepted start.
- MTHI/MTLO:
  - When busy=0, hi_we/lo_we write wdata at the next edge.
  - When busy=1 the write is ignored.
  - hi_we and lo_we may be asserted together.
  - start and a write in the same idle cycle: the write lands first, then the operation result overwrites HI/LO at completion.
- hi/lo outputs hold their previous values throughout an operation; there are no intermediate values.

Optional Feature:
- Macro MULT_ACCUM_EN.
- Defined: op codes 4-7 are MADD, MADDU, MSUB, MSUBU. The product is added to or subtracted from the prior {hi,lo} in the FIX state, modulo 2^(2*WIDTH). Same latency as MULT.
- Undefined: op codes 4-7 are treated as no-ops. start is accepted, busy is never raised, hi/lo are unchanged, and done is not pulsed.

Decomposition:
- Package mdu_pkg holds:
  - op_t enum: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MADD=4, OP_MADDU=5, OP_MSUB=6, OP_MSUBU=7.
  - state_t enum: IDLE, MUL, DIV, FIX.
  - Helper function is_div(op).
- Sub-module: mdu_divider, the restoring divide datapath (partial-remainder register, quotient shift, iteration counter). The multiply shift-add datapath stays in the parent.

Test Plan:
- MULTU a=0x00000200, b=0x00000030 -> done at E0+33, hi=0x00000000, lo=0x00006000, busy high for 33 cycles.
- MULT a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0, lo=1. MULTU with the same operands -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x00003100, b=0 -> lo=0xFFFFFFFF, hi=0x00003100, div_by_zero=1. A following DIVU 0x3100/4 -> lo=0x00000C40, hi=0, div_by_zero=0.
- Robustness:
  - A second start 5 cycles into a MULTU is ignored.
  - hi_we with wdata=0x1234 while busy leaves hi unchanged.
  - reset=0 at cycle 10 of a DIV -> busy=0, hi=lo=0 immediately, no done pulse.
